contrast_event_arbiter: RTL and testbench
=========================================

Name: contrast_event_arbiter

Overview:
- SpartanMC peripheral that collects PWM on-value change events from NUMBER_OF_BOXES contrast box stages and queues them for the CPU.
- Each event is a record {box index, 10-bit on-value}.
- A round-robin arbiter shares the single FIFO write port between all boxes. The CPU drains the FIFO through the peripheral bus; an interrupt line flags non-empty.
- Sits beside the contrast box peripheral, fed by its per-box on-time bus and per-box change pulses.

Parameters:
- BASE_ADR, 10'h0, peripheral base address on addr_peri.
- NUMBER_OF_BOXES, 2, number of event sources (1..8).
- PWM_REG_WIDTH, 10, width of each on-value.
- FIFO_DEPTH, 16, record FIFO depth (power of two, 2..32).

Ports:
- clk_peri  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- do_peri  input  18  data bus from MC.
- di_peri  output  18  data bus to MC.
- addr_peri  input  10  address bus from MC.
- access_peri  input  1  peripheral access strobe.
- wr_peri  input  1  write enable (qualifies access_peri).
- pwm_on_time  input  PWM_REG_WIDTH*NUMBER_OF_BOXES  packed on-values; box i at [10i+9:10i].
- pwm_changed  input  NUMBER_OF_BOXES  one-cycle change pulse per box.
- irq  output  1  high while FIFO non-empty and IRQ_EN=1.

Behaviour:
- Register map (offset from BASE_ADR):
  - 0 STATUS. Read fields: [0] not_empty, [1] full, [2] overflow (sticky), [8:3] level. Write 1 to bit 2 clears overflow.
  - 1 DATA. Read pops the head record: [13:10] box index, [9:0] value, [17:14] zero. Reading when empty returns 0, pops nothing, changes no state.
  - 2 CONTROL (R/W). [8:0] source enable mask (bits >= NUMBER_OF_BOXES read 0), [9] IRQ_EN, [10] flush (self-clearing, reads 0).
- Other offsets: reads return 0, writes are ignored.
- Read latency: di_peri is valid the cycle after the read access and is 0 in every other cycle. The pop takes effect at the access edge.
- Reset: mask=0, IRQ_EN=0, pending=0, FIFO empty, overflow=0, round-robin pointer=0, di_peri=0, irq=0.
- Capture, per box i:
  - If pwm_changed[i] and mask[i] are both high, set pending[i] and latch snapshot[i] = pwm_on_time slice i.
  - If pending[i] is already set, the snapshot is overwritten with the newest value and overflow is set (older sample lost).
- Arbitration (one grant per cycle):
  - A grant requires pending != 0 and FIFO not full.
  - Winner is the first pending box searching from ptr, ptr+1, ... mod NUMBER_OF_BOXES.
  - On grant: push {i, snapshot[i]}, clear pending[i], set ptr = i+1 (wraps to 0).
  - Grant-to-push latency is 0 cycles: the record is written at the same edge.
  - Events are therefore visible in the FIFO at the earliest 1 cycle after their pulse (capture edge, then push edge).
- Simultaneous events:
  - Pulse on box i in the same cycle i is granted: the old snapshot is pushed, pending[i] stays set with the new value, and overflow is not set.
  - Pop and grant in the same cycle when the FIFO is full: the grant is blocked that cycle (no bypass); the push happens next cycle.
  - Pop and push in the same cycle when not full: level unchanged.
- Full: pending bits are held; sources keep coalescing as described under Capture.
- Mask bit cleared: that box's pending bit is cleared immediately and its snapshot discarded.
- Flush: empties the FIFO, clears all pending bits, resets ptr to 0, keeps overflow. A flush in the same cycle as a grant or pop wins.
- Reset asserted mid-operation: all state returns to reset values asynchronously.

Decomposition:
- Shared package contrast_event_pkg:
  - register offsets STATUS=0, DATA=1, CONTROL=2;
  - STATUS and CONTROL bit positions;
  - record field positions;
  - BOX_IDX_W = 4.
- Sub-module contrast_event_fifo: synchronous single-clock FIFO with push, pop, flush, full, empty, level. Width 14, depth FIFO_DEPTH.
- Arbiter, capture logic and register interface stay in the top module.

Test Plan:
- Basic event: mask=0x3, IRQ_EN=1, pulse box1 with value 0x155 -> irq rises; STATUS reads level=1, not_empty=1; DATA reads 0x0555 (box 1, value 0x155); irq falls after the pop.
- Simultaneous: pulse boxes 0 (0x010) and 1 (0x020) in the same cycle with ptr=0 -> FIFO order {0,0x010} then {1,0x020}. Repeat with ptr=1 -> box 1 first.
- Fill: FIFO_DEPTH=16, push 16 events -> full=1, level=16. A further pulse on box 0 (0x3FF) is held pending. One DATA pop -> the held record is pushed next cycle and level returns to 16.
- Coalesce while full: with the FIFO full, pulse box 0 twice (0x100, then 0x200) -> overflow=1. After a pop, the record pushed is {0,0x200}. Writing 0x4 to STATUS clears overflow.
- Masking and flush: mask=0x1, pulse box 1 -> no record. Fill 5 records, write CONTROL bit 10 -> level=0, irq=0, overflow unchanged. DATA read when empty returns 0.
- Async reset mid-burst: assert reset between clock edges while level=7 and pending=0x3 -> di_peri=0, irq=0, STATUS=0, CONTROL=0 immediately.

Source files
------------

// File: rtl/contrast_event_pkg.sv
// Shared register map, bit positions and record layout for the contrast event arbiter.
package contrast_event_pkg;

    localparam int BOX_IDX_W = 4;

    localparam logic [9:0] REG_STATUS  = 10'd0;
    localparam logic [9:0] REG_DATA    = 10'd1;
    localparam logic [9:0] REG_CONTROL = 10'd2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_LEVEL_LSB = 3;
    localparam int ST_LEVEL_W   = 6;

    localparam int CTL_MASK_LSB = 0;
    localparam int CTL_MASK_W   = 9;
    localparam int CTL_IRQ_EN   = 9;
    localparam int CTL_FLUSH    = 10;

    localparam int REC_VAL_LSB  = 0;
    localparam int REC_IDX_LSB  = 10;

endpackage

// File: rtl/contrast_event_fifo.sv
// Single-clock record FIFO with synchronous flush; the head is visible combinationally on pop_data.
module contrast_event_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush takes priority over any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/contrast_event_arbiter.sv
// Captures per-box PWM on-value change events, arbitrates them round-robin into a record FIFO
// and exposes the FIFO, status and control to the SpartanMC peripheral bus.
module contrast_event_arbiter
    import contrast_event_pkg::*;
#(
    parameter logic [9:0] BASE_ADR        = 10'h0,
    parameter int         NUMBER_OF_BOXES = 2,
    parameter int         PWM_REG_WIDTH   = 10,
    parameter int         FIFO_DEPTH      = 16
) (
    input  logic                                     clk_peri,
    input  logic                                     reset,
    input  logic [17:0]                              do_peri,
    output logic [17:0]                              di_peri,
    input  logic [9:0]                               addr_peri,
    input  logic                                     access_peri,
    input  logic                                     wr_peri,
    input  logic [PWM_REG_WIDTH*NUMBER_OF_BOXES-1:0] pwm_on_time,
    input  logic [NUMBER_OF_BOXES-1:0]               pwm_changed,
    output logic                                     irq
);

    localparam int NB    = NUMBER_OF_BOXES;
    localparam int PW    = PWM_REG_WIDTH;
    localparam int REC_W = BOX_IDX_W + PW;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [9:0]           offset;
    logic                 hit, rd_hit, wr_hit;
    logic                 flush_req, pop_req, ovf_clr, ovf_set;
    logic [NB-1:0]        mask, mask_next;
    logic                 irq_en;
    logic [NB-1:0]        pending, pending_next, cap, grant;
    logic [PW-1:0]        snap [NB];
    logic [BOX_IDX_W-1:0] ptr;
    logic                 overflow;
    logic                 hi_hit, lo_hit, gnt_valid;
    logic [BOX_IDX_W-1:0] hi_idx, lo_idx, gnt_idx;
    logic [PW-1:0]        hi_val, lo_val, gnt_val;
    logic [REC_W-1:0]     fifo_wdata, fifo_rdata;
    logic                 fifo_full, fifo_empty;
    logic [LVL_W-1:0]     fifo_level;
    logic [17:0]          rd_data;
    logic                 unused_bus;

    assign unused_bus = ^do_peri;

    assign offset    = addr_peri - BASE_ADR;
    assign hit       = access_peri && (offset <= REG_CONTROL);
    assign rd_hit    = hit && !wr_peri;
    assign wr_hit    = hit && wr_peri;
    assign flush_req = wr_hit && (offset == REG_CONTROL) && do_peri[CTL_FLUSH];
    assign ovf_clr   = wr_hit && (offset == REG_STATUS) && do_peri[ST_OVERFLOW];
    assign pop_req   = rd_hit && (offset == REG_DATA) && !fifo_empty;
    assign cap       = pwm_changed & mask;

    always_comb begin
        mask_next = mask;
        if (wr_hit && (offset == REG_CONTROL)) begin
            mask_next = do_peri[CTL_MASK_LSB +: NB];
        end
    end

    // Round-robin: first pending box at or above ptr, else first pending box from 0.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        hi_val = '0;
        lo_hit = 1'b0;
        lo_idx = '0;
        lo_val = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_hit = 1'b1;
                lo_idx = BOX_IDX_W'(i);
                lo_val = snap[i];
                if (BOX_IDX_W'(i) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = BOX_IDX_W'(i);
                    hi_val = snap[i];
                end
            end
        end
        gnt_idx   = hi_hit ? hi_idx : lo_idx;
        gnt_val   = hi_hit ? hi_val : lo_val;
        gnt_valid = (hi_hit || lo_hit) && !fifo_full && !flush_req;
        grant     = '0;
        for (int i = 0; i < NB; i++) begin
            grant[i] = gnt_valid && (gnt_idx == BOX_IDX_W'(i));
        end
    end

    assign fifo_wdata = {gnt_idx, gnt_val};

    // A pulse on the box being granted replaces the outgoing sample without loss.
    always_comb begin
        pending_next = ((pending & ~grant) | cap) & mask_next;
        if (flush_req) pending_next = '0;
    end

    assign ovf_set = |(cap & pending & ~grant);

    always_ff @(posedge clk_peri or posedge reset) begin
        if (reset) begin
            mask     <= '0;
            irq_en   <= 1'b0;
            pending  <= '0;
            ptr      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NB; i++) snap[i] <= '0;
        end else begin
            mask    <= mask_next;
            pending <= pending_next;
            if (wr_hit && (offset == REG_CONTROL)) irq_en <= do_peri[CTL_IRQ_EN];
            overflow <= ovf_set || (overflow && !ovf_clr);
            for (int i = 0; i < NB; i++) begin
                if (cap[i]) snap[i] <= pwm_on_time[i*PW +: PW];
            end
            if (flush_req) begin
                ptr <= '0;
            end else if (gnt_valid) begin
                ptr <= (gnt_idx == BOX_IDX_W'(NB - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    contrast_event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_peri),
        .rst       (reset),
        .push      (gnt_valid),
        .push_data (fifo_wdata),
        .pop       (pop_req),
        .flush     (flush_req),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        rd_data = '0;
        case (offset)
            REG_STATUS: begin
                rd_data[ST_NOT_EMPTY]               = !fifo_empty;
                rd_data[ST_FULL]                    = fifo_full;
                rd_data[ST_OVERFLOW]                = overflow;
                rd_data[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(fifo_level);
            end
            REG_DATA: begin
                if (!fifo_empty) rd_data[REC_W-1:0] = fifo_rdata;
            end
            REG_CONTROL: begin
                rd_data[CTL_MASK_LSB +: NB] = mask;
                rd_data[CTL_IRQ_EN]         = irq_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_peri or posedge reset) begin
        if (reset) begin
            di_peri <= '0;
        end else begin
            di_peri <= rd_hit ? rd_data : '0;
        end
    end

    assign irq = irq_en && !fifo_empty;

endmodule

// File: tb/tb_contrast_event_arbiter.sv
// Directed bench for contrast_event_arbiter: two boxes, 16-deep FIFO, hand-computed register values.
module tb_contrast_event_arbiter;

    logic        clk_peri = 1'b0;
    logic        reset;
    logic [17:0] do_peri;
    logic [17:0] di_peri;
    logic [9:0]  addr_peri;
    logic        access_peri;
    logic        wr_peri;
    logic [19:0] pwm_on_time;
    logic [1:0]  pwm_changed;
    logic        irq;

    int total = 0;
    int bad   = 0;
    logic [17:0] rd;
    logic [17:0] exp_q[$];

    contrast_event_arbiter #(
        .BASE_ADR        (10'h0),
        .NUMBER_OF_BOXES (2),
        .PWM_REG_WIDTH   (10),
        .FIFO_DEPTH      (16)
    ) dut (
        .clk_peri    (clk_peri),
        .reset       (reset),
        .do_peri     (do_peri),
        .di_peri     (di_peri),
        .addr_peri   (addr_peri),
        .access_peri (access_peri),
        .wr_peri     (wr_peri),
        .pwm_on_time (pwm_on_time),
        .pwm_changed (pwm_changed),
        .irq         (irq)
    );

    always #5 clk_peri = ~clk_peri;

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_peri);
        #1;
    endtask

    task automatic write_reg(input logic [9:0] off, input logic [17:0] data);
        @(negedge clk_peri);
        addr_peri   = off;
        do_peri     = data;
        access_peri = 1'b1;
        wr_peri     = 1'b1;
        @(posedge clk_peri);
        #1;
        access_peri = 1'b0;
        wr_peri     = 1'b0;
        do_peri     = '0;
    endtask

    task automatic read_reg(input logic [9:0] off, output logic [17:0] data);
        @(negedge clk_peri);
        addr_peri   = off;
        access_peri = 1'b1;
        wr_peri     = 1'b0;
        @(posedge clk_peri);
        #1;
        access_peri = 1'b0;
        data        = di_peri;
    endtask

    task automatic pulse(input logic [1:0] m, input logic [9:0] v0, input logic [9:0] v1);
        @(negedge clk_peri);
        pwm_on_time = {v1, v0};
        pwm_changed = m;
        @(posedge clk_peri);
        #1;
        pwm_changed = '0;
    endtask

    initial begin
        reset       = 1'b1;
        do_peri     = '0;
        addr_peri   = '0;
        access_peri = 1'b0;
        wr_peri     = 1'b0;
        pwm_on_time = '0;
        pwm_changed = '0;
        repeat (3) @(posedge clk_peri);
        #1;
        check("rst_di", di_peri, 18'h0);
        check("rst_irq", {17'h0, irq}, 18'h0);
        @(negedge clk_peri);
        reset = 1'b0;
        read_reg(10'd0, rd); check("rst_status", rd, 18'h0);
        read_reg(10'd2, rd); check("rst_control", rd, 18'h0);

        // Basic event
        write_reg(10'd2, 18'h203);
        read_reg(10'd2, rd); check("ctl_rb", rd, 18'h203);
        pulse(2'b10, 10'h0, 10'h155);
        idle(1);
        check("basic_irq_hi", {17'h0, irq}, 18'h1);
        read_reg(10'd0, rd); check("basic_status", rd, 18'h009);
        read_reg(10'd1, rd); check("basic_data", rd, 18'h0555);
        check("basic_irq_lo", {17'h0, irq}, 18'h0);
        idle(1);
        check("di_idle_zero", di_peri, 18'h0);
        read_reg(10'd5, rd); check("unmapped_rd", rd, 18'h0);

        // Simultaneous events, ptr=0 then ptr=1
        pulse(2'b11, 10'h010, 10'h020);
        idle(2);
        read_reg(10'd1, rd); check("sim0_first", rd, 18'h0010);
        read_reg(10'd1, rd); check("sim0_second", rd, 18'h0420);
        pulse(2'b01, 10'h001, 10'h0);
        idle(1);
        read_reg(10'd1, rd); check("ptr_setup", rd, 18'h0001);
        pulse(2'b11, 10'h030, 10'h040);
        idle(2);
        read_reg(10'd1, rd); check("sim1_first", rd, 18'h0440);
        read_reg(10'd1, rd); check("sim1_second", rd, 18'h0030);

        // Fill to full, then a held event, then no-bypass pop
        for (int k = 0; k < 16; k++) pulse(2'b01, 10'h100 + 10'(k), 10'h0);
        idle(1);
        read_reg(10'd0, rd); check("full_status", rd, 18'h083);
        pulse(2'b01, 10'h3FF, 10'h0);
        idle(2);
        read_reg(10'd0, rd); check("held_status", rd, 18'h083);
        read_reg(10'd1, rd); check("full_pop", rd, 18'h0100);
        read_reg(10'd0, rd); check("no_bypass", rd, 18'h079);
        read_reg(10'd0, rd); check("refill_status", rd, 18'h083);

        // Coalesce while full
        pulse(2'b01, 10'h100, 10'h0);
        pulse(2'b01, 10'h200, 10'h0);
        read_reg(10'd0, rd); check("ovf_status", rd, 18'h087);
        read_reg(10'd1, rd); check("ovf_pop", rd, 18'h0101);
        idle(1);
        for (int k = 2; k < 16; k++) exp_q.push_back(18'h100 + 18'(k));
        exp_q.push_back(18'h03FF);
        exp_q.push_back(18'h0200);
        while (exp_q.size() > 0) begin
            read_reg(10'd1, rd);
            check("drain", rd, exp_q.pop_front());
        end
        read_reg(10'd0, rd); check("drained_status", rd, 18'h004);

        // Masking and flush (overflow stays set through flush)
        write_reg(10'd2, 18'h201);
        pulse(2'b10, 10'h0, 10'h0AA);
        idle(2);
        read_reg(10'd0, rd); check("masked_status", rd, 18'h004);
        for (int k = 0; k < 5; k++) pulse(2'b01, 10'h050 + 10'(k), 10'h0);
        idle(1);
        read_reg(10'd0, rd); check("five_status", rd, 18'h02D);
        check("five_irq", {17'h0, irq}, 18'h1);
        write_reg(10'd2, 18'h601);
        check("flush_irq", {17'h0, irq}, 18'h0);
        read_reg(10'd0, rd); check("flush_status", rd, 18'h004);
        read_reg(10'd2, rd); check("flush_ctl", rd, 18'h201);
        read_reg(10'd1, rd); check("empty_data", rd, 18'h0);
        write_reg(10'd0, 18'h004);
        read_reg(10'd0, rd); check("ovf_clear", rd, 18'h0);

        // Async reset mid-burst: level 7, pending both boxes
        write_reg(10'd2, 18'h203);
        for (int k = 0; k < 7; k++) pulse(2'b01, 10'h060 + 10'(k), 10'h0);
        idle(1);
        @(negedge clk_peri);
        pwm_on_time = {10'h071, 10'h070};
        pwm_changed = 2'b11;
        addr_peri   = 10'd0;
        access_peri = 1'b1;
        wr_peri     = 1'b0;
        @(posedge clk_peri);
        #1;
        pwm_changed = '0;
        access_peri = 1'b0;
        check("pre_rst_status", di_peri, 18'h039);
        check("pre_rst_irq", {17'h0, irq}, 18'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_di", di_peri, 18'h0);
        check("async_rst_irq", {17'h0, irq}, 18'h0);
        @(negedge clk_peri);
        reset = 1'b0;
        idle(1);
        read_reg(10'd0, rd); check("post_rst_status", rd, 18'h0);
        read_reg(10'd2, rd); check("post_rst_control", rd, 18'h0);
        read_reg(10'd1, rd); check("post_rst_data", rd, 18'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
